div_share_ctrl: RTL and testbench

Controller that shares the single iterative divider unit between two requesters: the pipeline execute stage (port 0) and a second issuer such as a coprocessor or debug path (port 1). It arbitrates round-robin and registers the winning operands. It holds the divider's `alucode`/`op1`/`op2` stable for the whole operation. It captures the result and returns it on the winner's response port with a valid/ready handshake. A watchdog converts a missing divider `valid` into an error response.

---
 rtl/div_share_ctrl.sv | 179 +++++++++++++++++
 tb/tb_div_share_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - round-robin sharing of one iterative divider between two requesters
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_share_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_alucode,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_alucode,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [5:0]  div_alucode,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic        div_valid,
  input  logic [31:0] div_result,
  output logic        busy
);
  localparam logic [5:0] ALU_DIV  = 6'h18;
  localparam logic [5:0] ALU_DIVU = 6'h19;
  localparam logic [5:0] ALU_REM  = 6'h1A;
  localparam logic [5:0] ALU_REMU = 6'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic          grant;
  logic          accept;
  logic          hit;
  logic          rsp_done;
  logic [CW-1:0] cnt;
  logic [5:0]    code;
  logic [31:0]   op1;
  logic [31:0]   op2;
  logic [5:0]    sel_code;
  logic [31:0]   sel_op1;
  logic [31:0]   sel_op2;
  logic [31:0]   hit_result;

  function automatic logic is_div(input logic [5:0] c);
    return (c == ALU_DIV) || (c == ALU_DIVU) || (c == ALU_REM) || (c == ALU_REMU);
  endfunction

  // Round robin: on contention the port not granted last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = ~last;
    else if (req1_valid)
      grant = 1'b1;
  end

  assign sel_code = grant ? req1_alucode : req0_alucode;
  assign sel_op1  = grant ? req1_op1 : req0_op1;
  assign sel_op2  = grant ? req1_op2 : req0_op2;

  assign accept     = (state == ST_IDLE) && (grant ? req1_valid : req0_valid);
  assign req0_ready = rst && (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = rst && (state == ST_IDLE) && req1_valid && grant;

  assign rsp0_valid = (state == ST_RESP) && !owner;
  assign rsp1_valid = (state == ST_RESP) && owner;
  assign rsp_done   = (state == ST_RESP) && (owner ? rsp1_ready : rsp0_ready);
  assign busy       = (state != ST_IDLE);

  // The divider restarts on any div code it sees, so the code is only exposed in RUN.
  assign div_alucode = (state == ST_RUN) ? code : 6'd0;
  assign div_op1     = op1;
  assign div_op2     = op2;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid;
  logic [5:0]  cache_code;
  logic [31:0] cache_op1;
  logic [31:0] cache_op2;
  logic [31:0] cache_result;

  assign hit = cache_valid && is_div(sel_code) && (cache_code == sel_code) &&
               (cache_op1 == sel_op1) && (cache_op2 == sel_op2);
  assign hit_result = cache_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid  <= 1'b0;
      cache_code   <= 6'd0;
      cache_op1    <= 32'd0;
      cache_op2    <= 32'd0;
      cache_result <= 32'd0;
    end else if (state == ST_RUN) begin
      if (div_valid) begin
        cache_valid  <= 1'b1;
        cache_code   <= code;
        cache_op1    <= op1;
        cache_op2    <= op2;
        cache_result <= div_result;
      end else if (cnt == CNT_LAST) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      code       <= 6'd0;
      op1        <= 32'd0;
      op2        <= 32'd0;
      rsp_result <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= grant;
            last  <= grant;
            code  <= sel_code;
            op1   <= sel_op1;
            op2   <= sel_op2;
            cnt   <= '0;
            if (hit) begin
              rsp_result <= hit_result;
              rsp_err    <= 1'b0;
              state      <= ST_RESP;
            end else if (is_div(sel_code)) begin
              state <= ST_RUN;
            end else begin
              rsp_result <= 32'd0;
              rsp_err    <= 1'b0;
              state      <= ST_RESP;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (div_valid) begin
            rsp_result <= div_result;
            rsp_err    <= 1'b0;
            state      <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_result <= 32'hFFFF_FFFF;
            rsp_err    <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - scoreboard bench for div_share_ctrl with a behavioural divider model
module tb_div_share_ctrl;
  localparam logic [5:0] ALU_DIV  = 6'h18;
  localparam logic [5:0] ALU_DIVU = 6'h19;
  localparam logic [5:0] ALU_REM  = 6'h1A;
  localparam logic [5:0] ALU_REMU = 6'h1B;
  localparam logic [5:0] ALU_ADD  = 6'h01;
  localparam int TIMEOUT = 64;
  localparam int DIV_LAT = 36;

  logic clk, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_alucode, req1_alucode;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic rsp_err, busy;
  logic [5:0] div_alucode;
  logic [31:0] div_op1, div_op2;
  logic div_valid;
  logic [31:0] div_result;

  div_share_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alucode(req0_alucode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alucode(req1_alucode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .div_alucode(div_alucode), .div_op1(div_op1), .div_op2(div_op2),
    .div_valid(div_valid), .div_result(div_result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic is_div(input logic [5:0] c);
    return (c == ALU_DIV) || (c == ALU_DIVU) || (c == ALU_REM) || (c == ALU_REMU);
  endfunction

  // RISC-V divide semantics, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_div(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_div = 32'd0;
    case (c)
      ALU_DIV:  if (b == 0) ref_div = 32'hFFFF_FFFF;
                else if (ovf) ref_div = a;
                else ref_div = 32'($signed(a) / $signed(b));
      ALU_DIVU: if (b == 0) ref_div = 32'hFFFF_FFFF;
                else ref_div = a / b;
      ALU_REM:  if (b == 0) ref_div = a;
                else if (ovf) ref_div = 32'd0;
                else ref_div = 32'($signed(a) % $signed(b));
      ALU_REMU: if (b == 0) ref_div = a;
                else ref_div = a % b;
      default:  ref_div = 32'd0;
    endcase
  endfunction

  // Divider model: pulses valid on the 35th consecutive cycle it sees a div code.
  int   dcnt;
  logic stall;
  always @(posedge clk or negedge rst) begin
    if (!rst) dcnt <= 0;
    else if (is_div(div_alucode)) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end
  assign div_valid  = !stall && is_div(div_alucode) && (dcnt == 34);
  assign div_result = ref_div(div_alucode, div_op1, div_op2);

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  exp_t cur;
  logic in_resp = 1'b0;
  int   errors = 0;
  int   checks = 0;
`ifdef DIV_RESULT_CACHE_EN
  logic        cv = 1'b0;
  logic [5:0]  cc;
  logic [31:0] ca, cb;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic issue(input int p, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    logic got;
    @(posedge clk); #1;
    if (p == 0) begin req0_valid = 1'b1; req0_alucode = c; req0_op1 = a; req0_op2 = b; end
    else        begin req1_valid = 1'b1; req1_alucode = c; req1_op1 = a; req1_op2 = b; end
    t = 0;
    got = 1'b0;
    while (!got && t < 400) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
      t++;
    end
    if (!got) bad("req_ready_wait");
    else begin
      e.port = p; e.acc = cyc; e.err = 1'b0;
      if (!is_div(c)) begin
        e.res = 32'd0; e.lat = 1;
      end else if (stall) begin
        e.res = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = TIMEOUT + 1;
`ifdef DIV_RESULT_CACHE_EN
        cv = 1'b0;
`endif
      end else begin
        e.res = ref_div(c, a, b); e.lat = DIV_LAT;
`ifdef DIV_RESULT_CACHE_EN
        if (cv && cc == c && ca == a && cb == b) e.lat = 1;
        cv = 1'b1; cc = c; ca = a; cb = b;
`endif
      end
      sb.push_back(e);
      gq.push_back(p);
    end
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per response and checks it is held until consumed.
  always @(negedge clk) begin
    if (rst && (rsp0_valid || rsp1_valid)) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        if (sb.size() == 0) bad("unexpected_response");
        else begin
          cur = sb.pop_front();
          chk("rsp_port", {31'd0, rsp1_valid}, cur.port);
          chk("rsp_result", rsp_result, cur.res);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
          chk("rsp_latency", cyc - cur.acc, cur.lat);
        end
      end else begin
        chk("rsp_hold", rsp_result, cur.res);
      end
      chk("rsp_one_hot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      chk("div_code_idle", {26'd0, div_alucode}, 32'd0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) in_resp = 1'b0;
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || in_resp) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) bad("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_div_alucode"}, {26'd0, div_alucode}, 32'd0);
    chk({tag, "_div_op1"}, div_op1, 32'd0);
    chk({tag, "_div_op2"}, div_op2, 32'd0);
  endtask

  function automatic logic [5:0] pick_code(input int k);
    case (k)
      0: return ALU_DIV;
      1: return ALU_DIVU;
      2: return ALU_REM;
      3: return ALU_REMU;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] rand_divisor();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 2));
    return $urandom;
  endfunction

  int rand_done;

  initial begin
    rst = 1'b0; stall = 1'b0;
    req0_valid = 1'b0; req0_alucode = 6'd0; req0_op1 = 32'd0; req0_op2 = 32'd0;
    req1_valid = 1'b0; req1_alucode = 6'd0; req1_op1 = 32'd0; req1_op2 = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #2 rst = 1'b1;

    // Contention from reset: port 0 first, then strict alternation.
    gq.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, ALU_DIV, $urandom, 32'($urandom_range(1, 1000)));
      for (int i = 0; i < 4; i++) issue(1, ALU_DIV, $urandom, 32'($urandom_range(1, 1000)));
    join
    drain();
    chk("grant_count", gq.size(), 8);
    for (int i = 0; i < gq.size(); i++) chk("grant_order", gq[i], i % 2);

    issue(0, ALU_DIVU, 32'd100, 32'd7);        drain();
    issue(1, ALU_REM, 32'hFFFF_FFF9, 32'd2);   drain();
    issue(1, ALU_DIVU, 32'd5, 32'd0);          drain();
    issue(0, ALU_ADD, 32'd3, 32'd4);           drain();

    // Watchdog, then a normal completion.
    stall = 1'b1;
    issue(0, ALU_DIV, 32'd9, 32'd3);           drain();
    stall = 1'b0;
    issue(0, ALU_DIV, 32'd9, 32'd3);           drain();

    issue(0, ALU_DIVU, 32'd100, 32'd7);        drain();
    issue(0, ALU_DIVU, 32'd100, 32'd7);        drain();

    // Response back-pressure on port 1 blocks port 0.
    rsp1_ready = 1'b0;
    fork
      issue(1, ALU_DIV, 32'd1000, 32'd10);
      begin
        repeat (3) @(posedge clk);
        issue(0, ALU_DIVU, 32'd77, 32'd3);
      end
      begin
        int t;
        t = 0;
        while (!rsp1_valid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) bad("hold_wait");
        repeat (10) begin
          @(negedge clk);
          chk("hold_no_grant", {31'd0, req0_ready}, 32'd0);
          chk("hold_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        end
        @(posedge clk); #1 rsp1_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of an operation.
    fork
      issue(0, ALU_DIV, 32'd50, 32'd5);
      begin
        int t;
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("midreset");
        sb.delete();
        in_resp = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        cv = 1'b0;
`endif
      end
    join
    repeat (3) @(negedge clk);
    rst = 1'b1;
    issue(0, ALU_DIV, 32'd20, 32'd4);          drain();

    // Random traffic on both ports with random response back-pressure.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(0, pick_code($urandom_range(0, 4)), $urandom, rand_divisor());
        rand_done++;
      end
      begin
        for (int i = 0; i < 8; i++)
          issue(1, pick_code($urandom_range(0, 4)), $urandom, rand_divisor());
        rand_done++;
      end
      begin
        while (rand_done < 2) begin
          @(posedge clk); #1;
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    bad("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
